// File: rtl/ray_scan_ctrl.sv
// Frame sequencer: walks an H_RES x V_RES raster, launches one primary ray per pixel and
// writes each returned (or timed-out) colour into the frame buffer.
module ray_scan_ctrl #(
    parameter int unsigned H_RES     = 8,
    parameter int unsigned V_RES     = 4,
    parameter int unsigned FB_AW     = 16,
    parameter logic [8:0]  FOCAL     = 9'd64,
    parameter int unsigned TIMEOUT   = 64,
    parameter logic [11:0] ERR_COLOR = 12'hF0F
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic [27:0]      cam_pos,
    output logic             busy,
    output logic             done,
    output logic             tr_valid,
    output logic [27:0]      tr_init,
    output logic [27:0]      tr_dir,
    input  logic             tr_ret,
    input  logic [11:0]      tr_dout,
    input  logic             tr_collision,
    output logic             fb_we,
    input  logic             fb_ready,
    output logic [FB_AW-1:0] fb_addr,
    output logic [11:0]      fb_data,
    output logic [15:0]      collision_cnt,
    output logic             err_flag
);

    localparam int unsigned XW = (H_RES > 1) ? $clog2(H_RES) : 1;
    localparam int unsigned YW = (V_RES > 1) ? $clog2(V_RES) : 1;
    localparam int unsigned TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    localparam logic [XW-1:0] X_LAST = XW'(H_RES - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(V_RES - 1);
    localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT - 1);
    localparam logic [9:0]    DX_OFS = 10'(H_RES / 2);
    localparam logic [8:0]    DY_OFS = 9'(V_RES / 2 - 1);

    localparam logic [2:0] StIdle  = 3'd0;
    localparam logic [2:0] StIssue = 3'd1;
    localparam logic [2:0] StWait  = 3'd2;
    localparam logic [2:0] StWrite = 3'd3;
    localparam logic [2:0] StDone  = 3'd4;

    logic [2:0]       state_q, state_d;
    logic [XW-1:0]    x_q, x_d;
    logic [YW-1:0]    y_q, y_d;
    logic [FB_AW-1:0] addr_q, addr_d;
    logic [TW-1:0]    timer_q, timer_d;
    logic [27:0]      init_q, init_d;
    logic [27:0]      dir_q, dir_d;
    logic [11:0]      data_q, data_d;
    logic [15:0]      coll_q, coll_d;
    logic             err_q, err_d;

    logic             last_pix;
    logic [XW-1:0]    x_nxt;
    logic [YW-1:0]    y_nxt;

    // Direction is {dx, dy, dz}; dy grows upwards so the top line looks up.
    function automatic logic [27:0] ray_dir(input logic [XW-1:0] px, input logic [YW-1:0] py);
        logic [9:0] dx;
        logic [8:0] dy;
        dx = 10'(px) - DX_OFS;
        dy = DY_OFS - 9'(py);
        return {dx, dy, FOCAL};
    endfunction

    assign last_pix = (x_q == X_LAST) && (y_q == Y_LAST);

    always_comb begin
        if (x_q == X_LAST) begin
            x_nxt = '0;
            y_nxt = y_q + YW'(1);
        end else begin
            x_nxt = x_q + XW'(1);
            y_nxt = y_q;
        end
    end

    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        addr_d  = addr_q;
        timer_d = timer_q;
        init_d  = init_q;
        dir_d   = dir_q;
        data_d  = data_q;
        coll_d  = coll_q;
        err_d   = err_q;

        if (abort) begin
            state_d = StIdle;
        end else begin
            case (state_q)
                StIdle: begin
                    if (start) begin
                        state_d = StIssue;
                        init_d  = cam_pos;
                        x_d     = '0;
                        y_d     = '0;
                        addr_d  = '0;
                        coll_d  = '0;
                        err_d   = 1'b0;
                        dir_d   = ray_dir('0, '0);
                    end
                end
                StIssue: begin
                    timer_d = '0;
                    state_d = StWait;
                end
                StWait: begin
                    if (tr_ret) begin
                        data_d  = tr_dout;
                        if (tr_collision && (coll_q != 16'hFFFF)) begin
                            coll_d = coll_q + 16'd1;
                        end
                        state_d = StWrite;
                    end else if (timer_q == T_LAST) begin
                        data_d  = ERR_COLOR;
                        err_d   = 1'b1;
                        state_d = StWrite;
                    end else begin
                        timer_d = timer_q + TW'(1);
                    end
                end
                StWrite: begin
                    if (fb_ready) begin
                        if (last_pix) begin
                            state_d = StDone;
                        end else begin
                            x_d     = x_nxt;
                            y_d     = y_nxt;
                            addr_d  = addr_q + FB_AW'(1);
                            dir_d   = ray_dir(x_nxt, y_nxt);
                            state_d = StIssue;
                        end
                    end
                end
                StDone: begin
                    state_d = StIdle;
                end
                default: begin
                    state_d = StIdle;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            x_q     <= '0;
            y_q     <= '0;
            addr_q  <= '0;
            timer_q <= '0;
            init_q  <= '0;
            dir_q   <= '0;
            data_q  <= '0;
            coll_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            addr_q  <= addr_d;
            timer_q <= timer_d;
            init_q  <= init_d;
            dir_q   <= dir_d;
            data_q  <= data_d;
            coll_q  <= coll_d;
            err_q   <= err_d;
        end
    end

    assign busy          = (state_q != StIdle);
    assign done          = (state_q == StDone);
    assign tr_valid      = (state_q == StIssue);
    // An abort in the write cycle must not let the frame buffer see a handshake.
    assign fb_we         = (state_q == StWrite) && !abort;
    assign tr_init       = init_q;
    assign tr_dir        = dir_q;
    assign fb_addr       = addr_q;
    assign fb_data       = data_q;
    assign collision_cnt = coll_q;
    assign err_flag      = err_q;

endmodule

// File: tb/tb_ray_scan_ctrl.sv
// Bench for ray_scan_ctrl: event-level frame model checked every cycle, an automatic tracer and
// frame-buffer responder, and directed frames pinned with hand-computed literals.
module tb_ray_scan_ctrl;

    localparam int H_RES   = 8;
    localparam int V_RES   = 4;
    localparam int FB_AW   = 16;
    localparam int TIMEOUT = 64;
    localparam int NPIX    = H_RES * V_RES;
    localparam logic [11:0] ERR_COLOR = 12'hF0F;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic             abort;
    logic [27:0]      cam_pos;
    logic             busy;
    logic             done;
    logic             tr_valid;
    logic [27:0]      tr_init;
    logic [27:0]      tr_dir;
    logic             tr_ret;
    logic [11:0]      tr_dout;
    logic             tr_collision;
    logic             fb_we;
    logic             fb_ready;
    logic [FB_AW-1:0] fb_addr;
    logic [11:0]      fb_data;
    logic [15:0]      collision_cnt;
    logic             err_flag;

    ray_scan_ctrl #(
        .H_RES    (H_RES),
        .V_RES    (V_RES),
        .FB_AW    (FB_AW),
        .FOCAL    (9'd64),
        .TIMEOUT  (TIMEOUT),
        .ERR_COLOR(ERR_COLOR)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .abort        (abort),
        .cam_pos      (cam_pos),
        .busy         (busy),
        .done         (done),
        .tr_valid     (tr_valid),
        .tr_init      (tr_init),
        .tr_dir       (tr_dir),
        .tr_ret       (tr_ret),
        .tr_dout      (tr_dout),
        .tr_collision (tr_collision),
        .fb_we        (fb_we),
        .fb_ready     (fb_ready),
        .fb_addr      (fb_addr),
        .fb_data      (fb_data),
        .collision_cnt(collision_cnt),
        .err_flag     (err_flag)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          due;
        logic [11:0] data;
        logic        coll;
    } resp_t;

    resp_t rq[$];

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    // Test knobs
    int              no_ans_pix = -1;
    int              stall_addr = -1;
    int              stall_left = 0;
    logic [NPIX-1:0] coll_mask  = '0;
    int              frame_id   = 0;
    int              start_cyc  = 0;

    // Frame model
    int          phase     = 0;  // 0 idle, 1 scanning, 2 done due
    int          k         = 0;
    int          issue_cyc = 0;
    bit          waiting   = 1'b0;
    bit          pend_wr   = 1'b0;
    logic [11:0] exp_data  = '0;
    int          m_coll    = 0;
    bit          m_err     = 1'b0;
    logic [27:0] m_cam     = '0;

    // Logs for literal checks
    int               done_count = 0;
    int               done_cyc   = 0;
    logic [FB_AW-1:0] wr_addr_log[$];
    logic [11:0]      wr_data_log[$];
    int               issue_cyc_of[NPIX];
    int               first_we_of[NPIX];
    int               we_cycles_of[NPIX];
    logic [27:0]      dir_log[NPIX];
    logic [27:0]      init_log[NPIX];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [11:0] color_of(input int f, input int p);
        return 12'(p * 149 + f * 23 + 7);
    endfunction

    function automatic logic [27:0] exp_dir(input int p);
        int         dx;
        int         dy;
        logic [9:0] dxv;
        logic [8:0] dyv;
        dx  = (p % H_RES) - H_RES / 2;
        dy  = (V_RES / 2 - 1) - (p / H_RES);
        dxv = 10'(dx);
        dyv = 9'(dy);
        return {dxv, dyv, 9'd64};
    endfunction

    // Tracer return and frame-buffer ready driver
    initial begin
        tr_ret       = 1'b0;
        tr_dout      = '0;
        tr_collision = 1'b0;
        fb_ready     = 1'b1;
        forever begin
            @(posedge clk);
            cyc++;
            #1;
            tr_ret       = 1'b0;
            tr_dout      = '0;
            tr_collision = 1'b0;
            while (rq.size() > 0 && rq[0].due < cyc) void'(rq.pop_front());
            if (rq.size() > 0 && rq[0].due == cyc) begin
                tr_ret       = 1'b1;
                tr_dout      = rq[0].data;
                tr_collision = rq[0].coll;
                void'(rq.pop_front());
            end
            if (fb_we && stall_addr >= 0 && int'(fb_addr) == stall_addr && stall_left > 0) begin
                fb_ready = 1'b0;
                stall_left--;
            end else begin
                fb_ready = 1'b1;
            end
        end
    end

    // Compare process: model state is checked first, then advanced with this cycle's inputs.
    initial begin
        bit    exp_valid;
        bit    exp_we;
        resp_t r;
        forever begin
            @(negedge clk);
            if (rst) begin
                phase   = 0;
                waiting = 1'b0;
                pend_wr = 1'b0;
                m_coll  = 0;
                m_err   = 1'b0;
                m_cam   = '0;
            end else begin
                exp_valid = (phase == 1) && (cyc == issue_cyc);
                exp_we    = (phase == 1) && pend_wr && !abort;
                check("busy", busy, phase != 0);
                check("done", done, phase == 2);
                check("tr_valid", tr_valid, exp_valid);
                check("fb_we", fb_we, exp_we);
                check("collision_cnt", collision_cnt, m_coll);
                check("err_flag", err_flag, m_err);
                if (exp_valid) begin
                    check("tr_dir", tr_dir, exp_dir(k));
                    check("tr_init", tr_init, m_cam);
                    issue_cyc_of[k] = cyc;
                    dir_log[k]      = tr_dir;
                    init_log[k]     = tr_init;
                    if (k == no_ans_pix) begin
                        // Stray returns land in the WRITE and next ISSUE cycles.
                        r.data = 12'hBAD;
                        r.coll = 1'b1;
                        r.due  = cyc + TIMEOUT + 1;
                        rq.push_back(r);
                        r.due  = cyc + TIMEOUT + 2;
                        rq.push_back(r);
                    end else begin
                        r.due  = cyc + 1;
                        r.data = color_of(frame_id, k);
                        r.coll = coll_mask[k];
                        rq.push_back(r);
                    end
                end
                if (exp_we) begin
                    check("fb_addr", fb_addr, k);
                    check("fb_data", fb_data, exp_data);
                end
                if (phase == 1 && fb_we) begin
                    we_cycles_of[k]++;
                    if (first_we_of[k] < 0) first_we_of[k] = cyc;
                end
                if (fb_we && fb_ready) begin
                    wr_addr_log.push_back(fb_addr);
                    wr_data_log.push_back(fb_data);
                end
                if (done) begin
                    done_count++;
                    done_cyc = cyc;
                end

                if (abort) begin
                    phase   = 0;
                    waiting = 1'b0;
                    pend_wr = 1'b0;
                end else if (phase == 0) begin
                    if (start) begin
                        phase     = 1;
                        k         = 0;
                        issue_cyc = cyc + 1;
                        m_coll    = 0;
                        m_err     = 1'b0;
                        m_cam     = cam_pos;
                        waiting   = 1'b0;
                        pend_wr   = 1'b0;
                    end
                end else if (phase == 2) begin
                    phase = 0;
                end else if (cyc == issue_cyc) begin
                    waiting = 1'b1;
                end else if (waiting) begin
                    if (tr_ret) begin
                        exp_data = tr_dout;
                        if (tr_collision && m_coll < 65535) m_coll++;
                        waiting = 1'b0;
                        pend_wr = 1'b1;
                    end else if (cyc == issue_cyc + TIMEOUT) begin
                        exp_data = ERR_COLOR;
                        m_err    = 1'b1;
                        waiting  = 1'b0;
                        pend_wr  = 1'b1;
                    end
                end else if (pend_wr && fb_ready) begin
                    pend_wr = 1'b0;
                    if (k == NPIX - 1) begin
                        phase = 2;
                    end else begin
                        k++;
                        issue_cyc = cyc + 1;
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_logs();
        wr_addr_log.delete();
        wr_data_log.delete();
        for (int i = 0; i < NPIX; i++) begin
            issue_cyc_of[i] = -1;
            first_we_of[i]  = -1;
            we_cycles_of[i] = 0;
            dir_log[i]      = '0;
            init_log[i]     = '0;
        end
    endtask

    task automatic start_frame();
        clear_logs();
        frame_id++;
        start     = 1'b1;
        start_cyc = cyc;
        tick();
        start = 1'b0;
    endtask

    task automatic run_until_done(input string name, input int limit);
        int d0 = done_count;
        int n  = 0;
        while (done_count == d0 && n < limit) begin
            tick();
            n++;
        end
        if (done_count == d0) begin
            checks++;
            failures++;
            $display("FAIL %s: done not seen within %0d cycles", name, limit);
        end
    endtask

    task automatic wait_write(input string name, input int addr, input int limit);
        int n = 0;
        while (!(fb_we && int'(fb_addr) == addr) && n < limit) begin
            tick();
            n++;
        end
        if (!(fb_we && int'(fb_addr) == addr)) begin
            checks++;
            failures++;
            $display("FAIL %s: write to %0d not seen within %0d cycles", name, addr, limit);
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int d_done;
        rst     = 1'b1;
        start   = 1'b0;
        abort   = 1'b0;
        cam_pos = '0;
        clear_logs();
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        check("reset_ctrl", {busy, done, tr_valid, fb_we, err_flag}, 5'b0);
        check("reset_tr_init", tr_init, 28'h0);
        check("reset_tr_dir", tr_dir, 28'h0);
        check("reset_fb_addr", fb_addr, 16'h0);
        check("reset_fb_data", fb_data, 12'h0);
        check("reset_coll", collision_cnt, 16'h0);
        tick();

        // Frame A: prompt returns, 10 collisions, cam_pos changes mid-frame
        coll_mask = '0;
        for (int i = 0; i < 10; i++) coll_mask[i*3] = 1'b1;
        cam_pos = 28'hABC1234;
        start_frame();
        cam_pos = 28'h5555555;
        run_until_done("a_done", 400);
        check("a_busy_after_done", busy, 1'b0);
        check("a_done_cycle", done_cyc - start_cyc, 97);
        check("a_write_count", wr_addr_log.size(), 32);
        check("a_first_addr", wr_addr_log[0], 0);
        check("a_last_addr", wr_addr_log[wr_addr_log.size()-1], 31);
        check("a_dir_0_0", dir_log[0], {10'h3FC, 9'h001, 9'd64});
        check("a_dir_7_3", dir_log[31], {10'h003, 9'h1FE, 9'd64});
        check("a_init_last", init_log[31], 28'hABC1234);
        check("a_coll", collision_cnt, 16'd10);
        check("a_err", err_flag, 1'b0);
        tick();

        // Frame B: pixel 5 never answers, stray returns after the timeout
        check("b_coll_hold", collision_cnt, 16'd10);
        coll_mask  = '0;
        no_ans_pix = 5;
        start_frame();
        check("b_coll_cleared", collision_cnt, 16'd0);
        run_until_done("b_done", 600);
        check("b_wait_span", first_we_of[5] - issue_cyc_of[5], TIMEOUT + 1);
        check("b_data5", wr_data_log[5], 12'hF0F);
        check("b_write_count", wr_addr_log.size(), 32);
        check("b_err", err_flag, 1'b1);
        check("b_coll", collision_cnt, 16'd0);
        no_ans_pix = -1;
        tick();

        // Frame C: frame buffer stalls pixel 2 for 4 cycles
        check("c_err_hold", err_flag, 1'b1);
        stall_addr = 2;
        stall_left = 4;
        start_frame();
        check("c_err_cleared", err_flag, 1'b0);
        run_until_done("c_done", 400);
        check("c_we_cycles2", we_cycles_of[2], 5);
        check("c_issue_gap", issue_cyc_of[3] - first_we_of[2], 5);
        check("c_write_count", wr_addr_log.size(), 32);
        stall_addr = -1;
        tick();

        // Frame D: mid-frame start ignored, abort during an accepted-looking write
        d_done = done_count;
        start_frame();
        wait_write("d_wait1", 1, 50);
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_write("d_wait3", 3, 50);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("d_busy_after_abort", busy, 1'b0);
        check("d_we_after_abort", fb_we, 1'b0);
        repeat (5) tick();
        check("d_no_done", done_count, d_done);
        check("d_write_count", wr_addr_log.size(), 3);

        // Frame E: abort beats start in IDLE, then a clean restart from address 0
        start = 1'b1;
        abort = 1'b1;
        tick();
        start = 1'b0;
        abort = 1'b0;
        check("e_abort_wins", busy, 1'b0);
        start_frame();
        run_until_done("e_done", 400);
        check("e_first_addr", wr_addr_log[0], 0);
        check("e_write_count", wr_addr_log.size(), 32);
        begin
            resp_t r;
            r.due  = cyc + 1;
            r.data = 12'h123;
            r.coll = 1'b1;
            rq.push_back(r);
        end
        repeat (3) tick();
        check("e_stray_coll", collision_cnt, 16'd0);
        check("e_stray_writes", wr_addr_log.size(), 32);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
